// File: rtl/ram_arbiter.sv
// Round-robin owner of a single-port sync RAM shared by two clients.
// Zero-fills the RAM after reset, then serves one command per cycle with in-order read returns.
module ram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    init_done,
   output logic                    ram_we,
   output logic                    ram_re,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state_reg;
   logic [ADDR_WIDTH:0]   cnt_reg;
   logic                  last_grant_reg;
   logic                  tag1_valid_reg, tag1_id_reg;
   logic                  tag2_valid_reg, tag2_id_reg;

   logic                  grant_valid;
   logic                  grant_id;
   logic                  handshake;
   logic [ADDR_WIDTH-1:0] addr_sl  [2];
   logic [DATA_WIDTH-1:0] wdata_sl [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign addr_sl[gi]   = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_sl[gi]  = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign req_ready[gi] = handshake && (grant_id == (gi != 0));
      end
   endgenerate

   // Ties go to whichever requester was not granted last.
   always_comb begin
      grant_valid = |req_valid;
      grant_id    = 1'b0;
      if (req_valid == 2'b10)
         grant_id = 1'b1;
      else if (req_valid == 2'b11)
         grant_id = ~last_grant_reg;
   end

   assign handshake = (state_reg == RUN) && grant_valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= INIT;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b1;
         ram_we         <= 1'b0;
         ram_re         <= 1'b0;
         ram_addr       <= '0;
         ram_wdata      <= '0;
         init_done      <= 1'b0;
         rsp_valid      <= 2'b00;
         rsp_data       <= '0;
         tag1_valid_reg <= 1'b0;
         tag1_id_reg    <= 1'b0;
         tag2_valid_reg <= 1'b0;
         tag2_id_reg    <= 1'b0;
      end else begin
         // Read data leaves the RAM one edge after re is sampled, so tags ride two stages.
         tag1_valid_reg <= handshake && !req_we[grant_id];
         tag1_id_reg    <= grant_id;
         tag2_valid_reg <= tag1_valid_reg;
         tag2_id_reg    <= tag1_id_reg;
         rsp_valid      <= {tag2_valid_reg && tag2_id_reg, tag2_valid_reg && !tag2_id_reg};
         if (tag2_valid_reg)
            rsp_data <= ram_rdata;

         case (state_reg)
            INIT: begin
               ram_re <= 1'b0;
               if (cnt_reg[ADDR_WIDTH]) begin
                  ram_we    <= 1'b0;
                  init_done <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  ram_we    <= 1'b1;
                  ram_addr  <= cnt_reg[ADDR_WIDTH-1:0];
                  ram_wdata <= '0;
                  cnt_reg   <= cnt_reg + 1'b1;
               end
            end
            RUN: begin
               if (handshake) begin
                  ram_we         <= req_we[grant_id];
                  ram_re         <= ~req_we[grant_id];
                  ram_addr       <= addr_sl[grant_id];
                  ram_wdata      <= wdata_sl[grant_id];
                  last_grant_reg <= grant_id;
               end else begin
                  ram_we <= 1'b0;
                  ram_re <= 1'b0;
               end
            end
            default: state_reg <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised and directed bench for ram_arbiter against a queue-free behavioural model of the
// shared RAM, the round-robin rule and the two-edge read return.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid, req_we, req_ready, rsp_valid;
   logic [7:0] req_addr;
   logic [15:0] req_wdata;
   logic [7:0] rsp_data;
   logic       init_done, ram_we, ram_re;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata, ram_rdata;
   logic [7:0] ram_mem [16];

   int n_cmp = 0;
   int n_fail = 0;

   ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
      .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // sync_ram stand-in: registered read, write on the same edge.
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_addr];
   end

   // Behavioural model: memory contents in command order, last winner, and the read
   // results scheduled for 2 edges after their handshake.
   typedef struct { logic v; logic id; logic [7:0] d; } ent_t;
   logic [7:0] m_mem [16];
   logic       m_last;
   int         m_edges;
   ent_t       p_a, p_b, p_c, h_next;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_last  = 1'b1;
      m_edges = 0;
      p_a = '{1'b0, 1'b0, 8'h00};
      p_b = p_a; p_c = p_a; h_next = p_a;
   endfunction

   task automatic drive_cycle(input logic [1:0] v, input logic [1:0] we,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              output logic [1:0] er, output logic [1:0] ev,
                              output logic [7:0] ed);
      logic       id;
      logic [3:0] a;
      @(negedge clk);
      m_edges++;
      p_c = p_b; p_b = p_a; p_a = h_next;
      h_next = '{1'b0, 1'b0, 8'h00};
      req_valid = v; req_we = we; req_addr = {a1, a0}; req_wdata = {d1, d0};
      #1;
      ev = p_c.v ? (p_c.id ? 2'b10 : 2'b01) : 2'b00;
      ed = p_c.d;
      er = 2'b00;
      if (m_edges >= 17) begin
         if (v == 2'b11) er = m_last ? 2'b01 : 2'b10;
         else            er = v;
      end
      if (er != 2'b00) begin
         id = er[1];
         a = id ? a1 : a0;
         m_last = id;
         if (we[id]) m_mem[a] = id ? d1 : d0;
         else        h_next = '{1'b1, id, m_mem[a]};
      end
   endtask

   task automatic test_reset();
      logic [1:0] er, ev;
      logic [7:0] ed;
      rst = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({ram_we, ram_re, ram_addr, ram_wdata, rsp_valid, init_done} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b re=%b addr=%h wd=%h rv=%b id=%b want all 0",
                     ram_we, ram_re, ram_addr, ram_wdata, rsp_valid, init_done);
         end
      end
      model_reset();
      rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         drive_cycle(2'b11, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, er, ev, ed);
         n_cmp++;
         if ({ram_we, ram_re, ram_addr, ram_wdata, init_done, req_ready} !== {1'b1, 1'b0, 4'(k-1), 8'h00, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL init_fill edge%0d: got we=%b re=%b addr=%0d wd=%h done=%b rdy=%b want we=1 re=0 addr=%0d wd=00 done=0 rdy=00",
                     k, ram_we, ram_re, ram_addr, ram_wdata, init_done, req_ready, k-1);
         end
      end
      drive_cycle(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, er, ev, ed);
      n_cmp++;
      if ({init_done, ram_we} !== 2'b10) begin
         n_fail++;
         $display("FAIL init_done edge17: got done=%b we=%b want done=1 we=0", init_done, ram_we);
      end
      for (int i = 0; i < 8; i++) begin
         if (i < 4) drive_cycle(2'b01, 2'b00, 4'($urandom_range(15)), 4'd0, 8'h00, 8'h00, er, ev, ed);
         else       drive_cycle(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, er, ev, ed);
         n_cmp++;
         if (req_ready !== er || rsp_valid !== ev || (ev != 0 && rsp_data !== ed)) begin
            n_fail++;
            $display("FAIL init_readback cyc%0d: got rdy=%b rv=%b rd=%h want rdy=%b rv=%b rd=%h",
                     i, req_ready, rsp_valid, rsp_data, er, ev, ed);
         end
      end
      $display("test_reset: done (%0d compared so far)", n_cmp);
   endtask

   // Each row: valid, we, addr0, addr1, data0, data1
   task automatic run_table(input string name, input logic [31:0] tbl [], input int extra_idle);
      logic [1:0] er, ev;
      logic [7:0] ed;
      for (int i = 0; i < tbl.size() + extra_idle; i++) begin
         if (i < tbl.size())
            drive_cycle(tbl[i][29:28], tbl[i][25:24], tbl[i][23:20], tbl[i][19:16],
                        tbl[i][15:8], tbl[i][7:0], er, ev, ed);
         else
            drive_cycle(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, er, ev, ed);
         n_cmp++;
         if (req_ready !== er) begin
            n_fail++;
            $display("FAIL %s ready cyc%0d: got %b want %b", name, i, req_ready, er);
         end
         n_cmp++;
         if (rsp_valid !== ev) begin
            n_fail++;
            $display("FAIL %s rsp_valid cyc%0d: got %b want %b", name, i, rsp_valid, ev);
         end
         if (ev != 2'b00) begin
            n_cmp++;
            if (rsp_data !== ed) begin
               n_fail++;
               $display("FAIL %s rsp_data cyc%0d: got %h want %h", name, i, rsp_data, ed);
            end
         end
      end
      $display("%s: done (%0d compared so far)", name, n_cmp);
   endtask

   task automatic test_single();
      logic [31:0] t [] = '{{2'b00, 2'b01, 2'b00, 2'b01, 4'd5, 4'd0, 8'hA5, 8'h00},
                            {2'b00, 2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00}};
      run_table("test_single", t, 4);
   endtask

   task automatic test_contention();
      logic [31:0] t [] = '{{2'b00, 2'b10, 2'b00, 2'b10, 4'd0, 4'd3, 8'h00, 8'h11},
                            {2'b00, 2'b11, 2'b00, 2'b00, 4'd3, 4'd3, 8'h00, 8'h00},
                            {2'b00, 2'b11, 2'b00, 2'b00, 4'd3, 4'd3, 8'h00, 8'h00},
                            {2'b00, 2'b11, 2'b00, 2'b00, 4'd3, 4'd3, 8'h00, 8'h00},
                            {2'b00, 2'b11, 2'b00, 2'b00, 4'd3, 4'd3, 8'h00, 8'h00}};
      run_table("test_contention", t, 4);
   endtask

   task automatic test_throughput();
      logic [31:0] t [8];
      for (int i = 0; i < 4; i++) begin
         t[i]   = {2'b00, 2'b01, 2'b00, 2'b01, 4'(i+1), 4'd0, 8'(i+1), 8'h00};
         t[i+4] = {2'b00, 2'b10, 2'b00, 2'b00, 4'd0, 4'(i+1), 8'h00, 8'h00};
      end
      run_table("test_back_to_back", t, 4);
   endtask

   task automatic test_race();
      logic [31:0] t [] = '{{2'b00, 2'b11, 2'b00, 2'b01, 4'd7, 4'd7, 8'h3C, 8'h00},
                            {2'b00, 2'b10, 2'b00, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00}};
      run_table("test_race", t, 4);
   endtask

   task automatic test_random();
      logic [1:0] pv = 2'b00, pwe = 2'b00, er, ev;
      logic [3:0] pa [2];
      logic [7:0] pd [2];
      logic [7:0] ed;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pv[i] && $urandom_range(2) != 0) begin
               pv[i] = 1'b1; pwe[i] = 1'($urandom_range(1));
               pa[i] = 4'($urandom_range(15)); pd[i] = 8'($urandom_range(255));
            end else if (pv[i] && $urandom_range(9) == 0) begin
               pv[i] = 1'b0;
            end
         end
         drive_cycle(pv, pwe, pa[0], pa[1], pd[0], pd[1], er, ev, ed);
         n_cmp++;
         if (req_ready !== er || rsp_valid !== ev || (ev != 0 && rsp_data !== ed)) begin
            n_fail++;
            $display("FAIL random cyc%0d: got rdy=%b rv=%b rd=%h want rdy=%b rv=%b rd=%h",
                     c, req_ready, rsp_valid, rsp_data, er, ev, ed);
         end
         pv = pv & ~er;
      end
      $display("test_random: done (%0d compared so far)", n_cmp);
   endtask

   task automatic test_midop_reset();
      logic [1:0] er, ev;
      logic [7:0] ed;
      logic [31:0] t [16];
      drive_cycle(2'b01, 2'b01, 4'd5, 4'd0, 8'hA5, 8'h00, er, ev, ed);
      drive_cycle(2'b01, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00, er, ev, ed);
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL midop read_handshake: got rdy=%b want 01", req_ready);
      end
      @(negedge clk);
      rst = 1'b0; req_valid = 2'b00;
      repeat (4) begin
         @(negedge clk);
         n_cmp++;
         if ({rsp_valid, init_done, ram_we, ram_re} !== 5'd0) begin
            n_fail++;
            $display("FAIL midop_in_reset: got rv=%b done=%b we=%b re=%b want all 0",
                     rsp_valid, init_done, ram_we, ram_re);
         end
      end
      model_reset();
      rst = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         drive_cycle(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, er, ev, ed);
         n_cmp++;
         if (rsp_valid !== 2'b00 || init_done !== (k == 17) || ram_we !== (k < 17) ||
             (k < 17 && ram_addr !== 4'(k-1))) begin
            n_fail++;
            $display("FAIL midop_refill edge%0d: got rv=%b done=%b we=%b addr=%0d want rv=00 done=%b we=%b addr=%0d",
                     k, rsp_valid, init_done, ram_we, ram_addr, k == 17, k < 17, k-1);
         end
      end
      for (int i = 0; i < 16; i++)
         t[i] = {2'b00, 2'b01, 2'b00, 2'b00, 4'(15-i), 4'd0, 8'h00, 8'h00};
      run_table("test_midop_readback", t, 4);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_throughput();
      test_race();
      test_random();
      test_midop_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
